alu_exec_stage: RTL and testbench

//  Registered execute stage that sits directly downstream of the ALU decoder.

---
 rtl/alu_exec_stage.sv | 76 +++++++
 tb/tb_alu_exec_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a 2-entry skid buffer and a registered in_ready
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam int EW = TAG_W + WIDTH + 4;
  logic [WIDTH:0]   sum, dif;
  logic             ovf_add, ovf_sub, slt, ill, cy, ov, is_sub;
  logic [WIDTH-1:0] res;
  logic [EW-1:0]    nxt, m_q, s_q;
  logic             m_valid, s_valid, rdy, in_fire, out_fire;
  always_comb begin
    sum     = {1'b0, src_a} + {1'b0, src_b};
    dif     = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif[WIDTH-1] != src_a[WIDTH-1]);
    slt     = dif[WIDTH-1] ^ ovf_sub;
    is_sub  = (alu_control == 3'b001) || (alu_control == 3'b101);
    ill     = (alu_control == 3'b100) || (alu_control[2:1] == 2'b11);
    res     = (alu_control == 3'b000) ? sum[WIDTH-1:0] :
              (alu_control == 3'b001) ? dif[WIDTH-1:0] :
              (alu_control == 3'b010) ? (src_a & src_b) :
              (alu_control == 3'b011) ? (src_a | src_b) :
              (alu_control == 3'b101) ? {{(WIDTH-1){1'b0}}, slt} : '0;
    cy      = (alu_control == 3'b000) ? sum[WIDTH] : is_sub ? dif[WIDTH] : 1'b0;
    ov      = (alu_control == 3'b000) ? ovf_add : is_sub ? ovf_sub : 1'b0;
    nxt     = {in_tag, ill, ov, cy, res == '0, res};
  end
  assign in_fire  = in_valid & rdy;
  assign out_fire = m_valid & out_ready;
  // Main always drives the outputs; skid only catches the op accepted while main stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy     <= 1'b1;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      rdy     <= 1'b1;
    end else if (out_fire || !m_valid) begin
      m_valid <= s_valid | in_fire;
      if (s_valid) m_q <= s_q;
      else if (in_fire) m_q <= nxt;
      s_valid <= 1'b0;
      rdy     <= 1'b1;
    end else if (in_fire) begin
      s_valid <= 1'b1;
      s_q     <= nxt;
      rdy     <= 1'b0;
    end
  end
  assign in_ready  = rdy;
  assign out_valid = m_valid;
  assign {out_tag, illegal, overflow, carry, zero, result} = m_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, zero, carry, overflow, illegal;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic [2:0]  alu_control = '0;
  logic [4:0]  in_tag = '0, out_tag;
  int errors = 0, checks = 0;

  alu_exec_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .carry(carry), .overflow(overflow), .illegal(illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1; alu_control = c; src_a = a; src_b = b; in_tag = t;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({zero, carry, overflow, illegal, out_tag} !== 9'h0) begin errors++; $display("FAIL reset_flags got=%b exp=0", {zero, carry, overflow, illegal, out_tag}); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(3'b000, 32'h7FFF_FFFF, 32'h1, 5'd1);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got=%h exp=80000000", result); end
    checks++; if ({zero, carry, overflow, illegal} !== 4'b0010) begin errors++; $display("FAIL add_ovf_flags zcoi got=%b exp=0010", {zero, carry, overflow, illegal}); end
    checks++; if (out_tag !== 5'd1) begin errors++; $display("FAIL add_tag got=%0d exp=1", out_tag); end
    drive(3'b000, 32'hFFFF_FFFF, 32'h1, 5'd2);
    step();
    checks++; if (result !== 32'h0 || {zero, carry, overflow, illegal} !== 4'b1100) begin errors++; $display("FAIL add_carry got=%h zcoi=%b exp=0 1100", result, {zero, carry, overflow, illegal}); end
    checks++; if (out_tag !== 5'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL add_b2b tag=%0d v=%b exp=2 1", out_tag, out_valid); end
  endtask

  task automatic test_sub_slt();
    out_ready = 1'b1;
    drive(3'b001, 32'd5, 32'd5, 5'd3);
    step();
    checks++; if (result !== 32'h0 || {zero, carry, overflow} !== 3'b110 || out_tag !== 5'd3) begin errors++; $display("FAIL sub_eq got=%h zco=%b tag=%0d exp=0 110 3", result, {zero, carry, overflow}, out_tag); end
    drive(3'b101, 32'hFFFF_FFFF, 32'h1, 5'd4);
    step();
    checks++; if (result !== 32'h1 || {zero, carry, overflow} !== 3'b010) begin errors++; $display("FAIL slt_neg got=%h zco=%b exp=1 010", result, {zero, carry, overflow}); end
    drive(3'b101, 32'h1, 32'hFFFF_FFFF, 5'd5);
    step();
    checks++; if (result !== 32'h0 || {zero, carry, overflow} !== 3'b100) begin errors++; $display("FAIL slt_pos got=%h zco=%b exp=0 100", result, {zero, carry, overflow}); end
    drive(3'b101, 32'h8000_0000, 32'h1, 5'd6);
    step();
    checks++; if (result !== 32'h1 || {zero, carry, overflow} !== 3'b011) begin errors++; $display("FAIL slt_ovf got=%h zco=%b exp=1 011", result, {zero, carry, overflow}); end
    drive(3'b001, 32'd3, 32'd5, 5'd7);
    step();
    checks++; if (result !== 32'hFFFF_FFFE || {zero, carry, overflow} !== 3'b000) begin errors++; $display("FAIL sub_neg got=%h zco=%b exp=fffffffe 000", result, {zero, carry, overflow}); end
    drive(3'b001, 32'h8000_0000, 32'h1, 5'd8);
    step();
    checks++; if (result !== 32'h7FFF_FFFF || {zero, carry, overflow} !== 3'b011) begin errors++; $display("FAIL sub_ovf got=%h zco=%b exp=7fffffff 011", result, {zero, carry, overflow}); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd10);
    step();
    checks++; if (out_valid !== 1'b1 || result !== 32'h0000_F000 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_main got v=%b r=%h rdy=%b exp=1 0000f000 1", out_valid, result, in_ready); end
    drive(3'b011, 32'h0000_F0F0, 32'h0000_0F00, 5'd11);
    step();
    checks++; if (in_ready !== 1'b0 || result !== 32'h0000_F000) begin errors++; $display("FAIL skid_full got rdy=%b r=%h exp=0 0000f000", in_ready, result); end
    drive(3'b000, 32'd10, 32'd20, 5'd12);
    repeat (2) begin
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h0000_F000 || out_tag !== 5'd10 || {zero, carry, overflow, illegal} !== 4'b0000) begin errors++; $display("FAIL skid_hold got rdy=%b v=%b r=%h tag=%0d exp=0 1 0000f000 10", in_ready, out_valid, result, out_tag); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (result !== 32'h0000_FFF0 || out_tag !== 5'd11 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_2 got r=%h tag=%0d rdy=%b exp=0000fff0 11 1", result, out_tag, in_ready); end
    step();
    checks++; if (result !== 32'd30 || out_tag !== 5'd12 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_3 got r=%h tag=%0d v=%b exp=1e 12 1", result, out_tag, out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(3'b111, 32'd5, 32'd3, 5'd13);
    step();
    checks++; if (out_valid !== 1'b1 || result !== 32'h0 || {zero, carry, overflow, illegal} !== 4'b1001 || out_tag !== 5'd13) begin errors++; $display("FAIL illegal_111 got r=%h zcoi=%b tag=%0d exp=0 1001 13", result, {zero, carry, overflow, illegal}, out_tag); end
    drive(3'b100, 32'hFFFF_FFFF, 32'h1, 5'd14);
    step();
    checks++; if (result !== 32'h0 || {zero, carry, overflow, illegal} !== 4'b1001) begin errors++; $display("FAIL illegal_100 got r=%h zcoi=%b exp=0 1001", result, {zero, carry, overflow, illegal}); end
    drive(3'b010, 32'h0000_00FF, 32'h0000_000F, 5'd15);
    step();
    checks++; if (result !== 32'h0000_000F || {zero, carry, overflow, illegal} !== 4'b0000) begin errors++; $display("FAIL after_illegal got r=%h zcoi=%b exp=f 0000", result, {zero, carry, overflow, illegal}); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 5'd20);
    step();
    drive(3'b000, 32'd2, 32'd2, 5'd21);
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill got rdy=%b v=%b exp=0 1", in_ready, out_valid); end
    drive(3'b000, 32'd3, 32'd3, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got v=%b rdy=%b exp=0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    repeat (3) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%b tag=%0d exp=0", out_valid, out_tag); end
    end
    drive(3'b001, 32'd9, 32'd4, 5'd23);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd5 || out_tag !== 5'd23) begin errors++; $display("FAIL flush_after got v=%b r=%h tag=%0d exp=1 5 23", out_valid, result, out_tag); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(3'b000, 32'd7, 32'd8, 5'd24);
    step();
    drive(3'b000, 32'd9, 32'd9, 5'd25);
    step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin errors++; $display("FAIL async_reset got v=%b rdy=%b r=%h exp=0 1 0", out_valid, in_ready, result); end
    step();
    rst = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_after got v=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_skid();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
